// File: rtl/map_grid_ctrl.sv
// Tile-grid controller: sweeps a MAP_W x MAP_H tile RAM to the start layout, then resolves
// round-robin player moves with collision detection. MAP_OBSTACLE_EN adds a fixed obstacle tile.
module map_grid_ctrl #(
  parameter int unsigned MAP_W     = 64,
  parameter int unsigned MAP_H     = 48,
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned TILE_W    = 3
`ifdef MAP_OBSTACLE_EN
  ,
  parameter int unsigned OBST_X    = 10,
  parameter int unsigned OBST_Y    = 40
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reinit,
  input  logic [8*N_PLAYERS-1:0] start_x,
  input  logic [8*N_PLAYERS-1:0] start_y,
  input  logic [N_PLAYERS-1:0]   mv_valid,
  input  logic [8*N_PLAYERS-1:0] mv_x,
  input  logic [8*N_PLAYERS-1:0] mv_y,
  output logic [N_PLAYERS-1:0]   mv_ready,
  output logic                   mv_done,
  output logic                   mv_crash,
  output logic [1:0]             mv_id,
  output logic [N_PLAYERS-1:0]   crashed,
  output logic                   init_done,
  input  logic [15:0]            rd_addr,
  output logic [TILE_W-1:0]      rd_data
);

  localparam int unsigned DEPTH  = MAP_W * MAP_H;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam logic [TILE_W-1:0] T_EMPTY = '0;
  localparam logic [TILE_W-1:0] T_FRAME = TILE_W'(1);
`ifdef MAP_OBSTACLE_EN
  localparam logic [TILE_W-1:0] T_OBST  = TILE_W'(7);
`endif

  logic [1:0]        r_state, w_state_nxt;
  logic [7:0]        r_x, r_y, w_x_nxt, w_y_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [1:0]        r_ptr, w_ptr_nxt;
  logic [1:0]        r_id, w_id_nxt;
  logic [ADDR_W-1:0] r_taddr, w_taddr_nxt;
  logic              r_oor, w_oor_nxt;
  logic [3:0]        r_crashed, w_crashed_nxt;
  logic              r_init_done;
  logic [TILE_W-1:0] r_q, r_rd_data;
  logic [TILE_W-1:0] r_mem [DEPTH];

  logic [7:0]        w_sx [N_PLAYERS];
  logic [7:0]        w_sy [N_PLAYERS];
  logic [31:0]       w_mx_pad, w_my_pad;
  logic [7:0]        w_mx [4];
  logic [7:0]        w_my [4];
  logic [3:0]        w_elig;
  logic              w_gnt_any;
  logic [1:0]        w_gnt_id, w_idx;
  logic [7:0]        w_tx, w_ty;
  logic              w_oor;
  logic [ADDR_W-1:0] w_taddr;
  logic [TILE_W-1:0] w_sweep_tile;
  logic              w_crash;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [TILE_W-1:0] w_wdata;

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_start
    assign w_sx[g] = start_x[8*g +: 8];
    assign w_sy[g] = start_y[8*g +: 8];
  end

  // Move targets padded to four slots so a 2-bit player index always selects cleanly
  assign w_mx_pad = 32'(mv_x);
  assign w_my_pad = 32'(mv_y);
  for (genvar g = 0; g < 4; g++) begin : g_mv
    assign w_mx[g] = w_mx_pad[8*g +: 8];
    assign w_my[g] = w_my_pad[8*g +: 8];
  end

  assign w_elig = 4'(mv_valid) & ~r_crashed;

  // Round-robin search starting at the pointer; reinit suppresses any grant
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = 2'd0;
    w_idx     = 2'd0;
    if (r_state == ST_READY && !reinit) begin
      for (int unsigned i = 0; i < N_PLAYERS; i++) begin
        w_idx = 2'((32'(r_ptr) + i) % N_PLAYERS);
        if (!w_gnt_any && w_elig[w_idx]) begin
          w_gnt_any = 1'b1;
          w_gnt_id  = w_idx;
        end
      end
    end
  end

  assign w_tx    = w_mx[w_gnt_id];
  assign w_ty    = w_my[w_gnt_id];
  assign w_oor   = (32'(w_tx) >= MAP_W) || (32'(w_ty) >= MAP_H);
  assign w_taddr = ADDR_W'(32'(w_ty) * MAP_W + 32'(w_tx));

  // Layout priority: player start (lowest index wins) > obstacle > frame > empty
  always_comb begin
    w_sweep_tile = T_EMPTY;
    if (r_x == 8'd0 || 32'(r_x) == MAP_W - 1 || r_y == 8'd0 || 32'(r_y) == MAP_H - 1)
      w_sweep_tile = T_FRAME;
`ifdef MAP_OBSTACLE_EN
    if (32'(r_x) == OBST_X && 32'(r_y) == OBST_Y)
      w_sweep_tile = T_OBST;
`endif
    for (int p = int'(N_PLAYERS) - 1; p >= 0; p--) begin
      if (w_sx[p] == r_x && w_sy[p] == r_y)
        w_sweep_tile = TILE_W'(2 + p);
    end
  end

  assign w_crash = r_oor || (r_q != T_EMPTY);

  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_addr;
    w_wdata = w_sweep_tile;
    if (!reinit) begin
      if (r_state == ST_CLEAR) begin
        w_we = 1'b1;
      end else if (r_state == ST_CHECK && !w_crash) begin
        w_we    = 1'b1;
        w_waddr = r_taddr;
        w_wdata = TILE_W'(32'd2 + 32'(r_id));
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_addr_nxt    = r_addr;
    w_ptr_nxt     = r_ptr;
    w_id_nxt      = r_id;
    w_taddr_nxt   = r_taddr;
    w_oor_nxt     = r_oor;
    w_crashed_nxt = r_crashed;
    if (reinit) begin
      w_state_nxt   = ST_CLEAR;
      w_x_nxt       = 8'd0;
      w_y_nxt       = 8'd0;
      w_addr_nxt    = '0;
      w_ptr_nxt     = 2'd0;
      w_crashed_nxt = 4'd0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          w_addr_nxt = r_addr + ADDR_W'(1);
          if (32'(r_x) == MAP_W - 1) begin
            w_x_nxt = 8'd0;
            if (32'(r_y) == MAP_H - 1) begin
              w_y_nxt     = 8'd0;
              w_addr_nxt  = '0;
              w_state_nxt = ST_READY;
            end else begin
              w_y_nxt = r_y + 8'd1;
            end
          end else begin
            w_x_nxt = r_x + 8'd1;
          end
        end
        ST_READY: begin
          if (w_gnt_any) begin
            w_id_nxt    = w_gnt_id;
            w_taddr_nxt = w_taddr;
            w_oor_nxt   = w_oor;
            w_ptr_nxt   = 2'((32'(w_gnt_id) + 32'd1) % N_PLAYERS);
            w_state_nxt = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_crash) w_crashed_nxt[r_id] = 1'b1;
          w_state_nxt = ST_READY;
        end
        default: w_state_nxt = ST_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_CLEAR;
      r_x         <= 8'd0;
      r_y         <= 8'd0;
      r_addr      <= '0;
      r_ptr       <= 2'd0;
      r_id        <= 2'd0;
      r_taddr     <= '0;
      r_oor       <= 1'b0;
      r_crashed   <= 4'd0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_addr      <= w_addr_nxt;
      r_ptr       <= w_ptr_nxt;
      r_id        <= w_id_nxt;
      r_taddr     <= w_taddr_nxt;
      r_oor       <= w_oor_nxt;
      r_crashed   <= w_crashed_nxt;
      r_init_done <= (w_state_nxt != ST_CLEAR);
    end
  end

  // Tile RAM: one write port, controller read port
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    if (w_gnt_any && !w_oor) r_q <= r_mem[w_taddr];
  end

  // Renderer read port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rd_data <= '0;
    else if (rd_addr < 16'(DEPTH)) r_rd_data <= r_mem[ADDR_W'(rd_addr)];
  end

  assign mv_ready  = w_gnt_any ? N_PLAYERS'(4'b0001 << w_gnt_id) : '0;
  assign mv_done   = (r_state == ST_CHECK) && !reinit;
  assign mv_crash  = mv_done && w_crash;
  assign mv_id     = r_id;
  assign crashed   = r_crashed[N_PLAYERS-1:0];
  assign init_done = r_init_done;
  assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_map_grid_ctrl.sv
// Randomized scoreboard bench for map_grid_ctrl against a grid/arbiter reference model.
module tb_map_grid_ctrl;

  localparam int W = 64;
  localparam int H = 48;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         reinit = 1'b0;
  logic [15:0]  start_x = {8'd50, 8'd10};
  logic [15:0]  start_y = {8'd30, 8'd10};
  logic [1:0]   mv_valid = '0;
  logic [15:0]  mv_x = '0;
  logic [15:0]  mv_y = '0;
  logic [1:0]   mv_ready;
  logic         mv_done;
  logic         mv_crash;
  logic [1:0]   mv_id;
  logic [1:0]   crashed;
  logic         init_done;
  logic [15:0]  rd_addr = '0;
  logic [2:0]   rd_data;

  int           grid [W*H];
  int           st_x [N] = '{10, 50};
  int           st_y [N] = '{10, 30};
  logic [1:0]   crashed_m;
  int           ptr_m;
  logic [2:0]   exp_q [$];
  int           nchk = 0;
  int           nerr = 0;

  always #5 clk = ~clk;

  map_grid_ctrl #(.MAP_W(W), .MAP_H(H), .N_PLAYERS(N), .TILE_W(3)) dut (
    .clk(clk), .rst(rst), .reinit(reinit), .start_x(start_x), .start_y(start_y),
    .mv_valid(mv_valid), .mv_x(mv_x), .mv_y(mv_y), .mv_ready(mv_ready),
    .mv_done(mv_done), .mv_crash(mv_crash), .mv_id(mv_id), .crashed(crashed),
    .init_done(init_done), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference layout straight from the tile rules
  function automatic void model_init();
    int t;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        t = 0;
        if (x == 0 || x == W-1 || y == 0 || y == H-1) t = 1;
`ifdef MAP_OBSTACLE_EN
        if (x == 10 && y == 40) t = 7;
`endif
        for (int p = N-1; p >= 0; p--)
          if (x == st_x[p] && y == st_y[p]) t = 2 + p;
        grid[y*W+x] = t;
      end
    end
    crashed_m = '0;
    ptr_m = 0;
  endfunction

  function automatic int arb(logic [1:0] elig, int ptr);
    int idx;
    for (int i = 0; i < N; i++) begin
      idx = (ptr + i) % N;
      if (elig[idx]) return idx;
    end
    return -1;
  endfunction

  // Monitor: every mv_done pops the oldest expected resolution
  task automatic monitor();
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (mv_done === 1'b1) begin
        chk("done_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("mv_id", mv_id, e[2:1]);
          chk("mv_crash", mv_crash, e[0]);
        end
      end
    end
  endtask

  task automatic wait_init();
    int n = 0;
    while (init_done !== 1'b1 && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("init_cycles", n, W*H);
  endtask

  task automatic do_reinit();
    reinit = 1'b1;
    @(posedge clk); #1;
    reinit = 1'b0;
    model_init();
    wait_init();
    chk("crashed_after_reinit", crashed, 0);
  endtask

  task automatic rd_chk(int addr);
    rd_addr = 16'(addr);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("rd_data[%0d]", addr), rd_data, grid[addr]);
    @(posedge clk); #1;
  endtask

  // Drive a request set for a fixed window; predict grants and resolutions
  task automatic run_reqs(logic [1:0] v, int x0, int y0, int x1, int y1);
    logic [1:0] pend = v;
    bit busy = 0;
    bit crash;
    int g, tx, ty;
    mv_x = {8'(x1), 8'(x0)};
    mv_y = {8'(y1), 8'(y0)};
    mv_valid = pend;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      g = busy ? -1 : arb(pend & ~crashed_m, ptr_m);
      chk("mv_ready", mv_ready, (g < 0) ? 2'b00 : 2'(1 << g));
      busy = 0;
      if (g >= 0) begin
        tx = (g == 0) ? x0 : x1;
        ty = (g == 0) ? y0 : y1;
        crash = 1;
        if (tx < W && ty < H) crash = (grid[ty*W+tx] != 0);
        if (crash) crashed_m[g] = 1'b1;
        else grid[ty*W+tx] = 2 + g;
        exp_q.push_back({2'(g), crash});
        ptr_m = (g + 1) % N;
        pend[g] = 1'b0;
        busy = 1;
      end
      @(posedge clk); #1;
      mv_valid = pend;
    end
    mv_valid = '0;
    chk("crashed", crashed, crashed_m);
  endtask

  initial begin
    int reinits = 0;
    int rx0, ry0, rx1, ry1;
    fork monitor(); join_none
    model_init();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_init_done", init_done, 0);
    chk("rst_mv_ready", mv_ready, 0);
    chk("rst_mv_done", mv_done, 0);
    chk("rst_crashed", crashed, 0);
    chk("rst_outputs", {mv_crash, mv_id, rd_data}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_init();

    rd_chk(0); rd_chk(10*64+10); rd_chk(30*64+50); rd_chk(65);

    run_reqs(2'b01, 11, 10, 0, 0);
    rd_chk(650); rd_chk(651);
    run_reqs(2'b10, 0, 0, 0, 5);
    run_reqs(2'b10, 0, 0, 70, 5);
    rd_chk(5*64);

    do_reinit();
    rd_chk(651);
    run_reqs(2'b11, 20, 20, 20, 20);
    rd_chk(20*64+20);
    run_reqs(2'b01, 70, 5, 0, 0);

    // Abandoned CHECK, then a restart in the middle of the sweep
    do_reinit();
    mv_x = 16'd30; mv_y = 16'd30; mv_valid = 2'b01;
    @(negedge clk);
    chk("abort_grant", mv_ready, 2'b01);
    @(posedge clk); #1;
    mv_valid = '0; reinit = 1'b1;
    @(negedge clk);
    chk("abort_no_done", mv_done, 0);
    @(posedge clk); #1;
    reinit = 1'b0;
    model_init();
    repeat (1000) @(posedge clk);
    #1;
    chk("mid_clear_init_low", init_done, 0);
    do_reinit();
    rd_chk(30*64+30);

    rd_chk(40*64+10);
    run_reqs(2'b01, 10, 40, 0, 0);
    rd_chk(40*64+10);

    for (int it = 0; it < 40; it++) begin
      if (crashed_m == 2'b11) begin
        if (reinits >= 6) break;
        do_reinit();
        reinits++;
      end
      rx0 = $urandom_range(0, 70); ry0 = $urandom_range(0, 52);
      rx1 = $urandom_range(0, 70); ry1 = $urandom_range(0, 52);
      if ($urandom_range(0, 3) == 0) begin rx1 = rx0; ry1 = ry0; end
      run_reqs(2'($urandom_range(1, 3)), rx0, ry0, rx1, ry1);
    end
    for (int i = 0; i < 30; i++) rd_chk($urandom_range(0, W*H-1));

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
